// File: rtl/arbitro_comparador.sv
// arbitro_comparador
//
// Round-robin arbiter and sequencer that shares one unsigned magnitude
// comparator between two requesters. A grant latches the winner's operand
// pair, the next cycle registers the compare result, and the cycle after
// that pulses the winner's ack together with res_valid. The last delivered
// result is decoded one-hot onto the LED bus.
//
// Optional feature macro: CONTADORES_EN
//   When defined, the cnt0/cnt1 ports and their saturating service counters
//   are present. When undefined, they are absent and nothing else changes.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   req0/req1  requests; held high with stable operands until the ack
//   a0,b0      operands of requester 0 (WIDTH bits)
//   a1,b1      operands of requester 1 (WIDTH bits)
//   ack0/ack1  one-cycle completion pulse to the served requester
//   res        bit0 = A>B, bit1 = B>A, 00 = equal; valid while an ack is high
//   res_valid  high exactly when ack0 or ack1 is high
//   busy       high while a service is in flight, including its ack cycle
//   leds       one-hot decode of the last delivered res
//   cnt0/cnt1  services completed per requester, saturating at 255
//              (CONTADORES_EN only)

module arbitro_comparador #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack0,
  output logic             ack1,
  output logic [1:0]       res,
  output logic             res_valid,
  output logic             busy,
`ifdef CONTADORES_EN
  output logic [3:0]       leds,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1
`else
  output logic [3:0]       leds
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             last;
  logic             sel;
  logic             grant;
  logic             grant_id;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       cmp_res;
  logic [3:0]       leds_dec;

  // Next-state and arbitration. Requests are only looked at in IDLE; when
  // both compete, the one that was not served last wins, otherwise the lone
  // requester wins regardless of the pointer.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    grant_id   = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant      = 1'b1;
          state_next = CMP;
          if (req0 && req1) begin
            grant_id = ~last;
          end else begin
            grant_id = req1;
          end
        end
      end
      CMP:     state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Unsigned compare of the latched pair. The two bits are mutually
  // exclusive, so 11 can never appear.
  always_comb begin
    cmp_res = {(op_b > op_a), (op_a > op_b)};
  end

  // One-hot LED decode of the result being delivered; 1000 is unused.
  always_comb begin
    case (res)
      2'b01:   leds_dec = 4'b0010;
      2'b10:   leds_dec = 4'b0100;
      default: leds_dec = 4'b0001;
    endcase
  end

  // State register plus the grant bookkeeping. Operands are captured only
  // on the grant edge, so later changes on a0/b0/a1/b1 cannot leak in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      sel   <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        last <= grant_id;
        sel  <= grant_id;
        op_a <= grant_id ? a1 : a0;
        op_b <= grant_id ? b1 : b0;
      end
    end
  end

  // Registered outputs. The ack pulse is produced on the edge that leaves
  // RESP, so it is visible during the following IDLE cycle; busy is kept
  // high through that ack cycle and only drops once nothing is pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res       <= 2'b00;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      leds      <= 4'b0000;
    end else begin
      if (state == CMP) begin
        res <= cmp_res;
      end
      ack0      <= (state == RESP) && !sel;
      ack1      <= (state == RESP) && sel;
      res_valid <= (state == RESP);
      busy      <= (state_next != IDLE) || (state == RESP);
      if (state == RESP) begin
        leds <= leds_dec;
      end
    end
  end

`ifdef CONTADORES_EN
  // Per-requester service counters. They step on the same edge that raises
  // the matching ack and stick at 255 instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0 <= 8'd0;
      cnt1 <= 8'd0;
    end else if (state == RESP) begin
      if (!sel && cnt0 != 8'hFF) begin
        cnt0 <= cnt0 + 8'd1;
      end
      if (sel && cnt1 != 8'hFF) begin
        cnt1 <= cnt1 + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_arbitro_comparador.sv
// tb_arbitro_comparador
//
// Self-checking bench for arbitro_comparador (WIDTH = 4). A behavioural
// model tracks, per rising edge, when the datapath is free, which requester
// wins, and on which edge its result is delivered; a negedge process
// compares every output against it. Directed scenarios add literal
// expectations, followed by a randomized phase.
// Define CONTADORES_EN to also exercise the saturating counters.

module tb_arbitro_comparador;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             ack0;
  logic             ack1;
  logic [1:0]       res;
  logic             res_valid;
  logic             busy;
  logic [3:0]       leds;
`ifdef CONTADORES_EN
  logic [7:0]       cnt0;
  logic [7:0]       cnt1;
`endif

  int n_checks;
  int n_fail;
  bit hold;

  arbitro_comparador #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .a0        (a0),
    .b0        (b0),
    .req1      (req1),
    .a1        (a1),
    .b1        (b1),
    .ack0      (ack0),
    .ack1      (ack1),
    .res       (res),
    .res_valid (res_valid),
    .busy      (busy),
`ifdef CONTADORES_EN
    .leds      (leds),
    .cnt0      (cnt0),
    .cnt1      (cnt1)
`else
    .leds      (leds)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a service granted on edge k is delivered on edge k+2
  // and the datapath accepts a new grant from edge k+3 on.
  int       edge_k;
  int       free_edge;
  int       pend_edge;
  bit       pend_id;
  bit [1:0] pend_res;
  bit       m_last;
  bit       e_ack0;
  bit       e_ack1;
  bit [1:0] e_res;
  bit       e_busy;
  bit [3:0] e_leds;
  int       e_cnt0;
  int       e_cnt1;

  function automatic bit [1:0] ref_compare(input int a, input int b);
    if (a > b) return 2'b01;
    if (b > a) return 2'b10;
    return 2'b00;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_k    = 0;
      free_edge = 0;
      pend_edge = -1;
      pend_id   = 1'b0;
      pend_res  = 2'b00;
      m_last    = 1'b1;
      e_ack0    = 1'b0;
      e_ack1    = 1'b0;
      e_res     = 2'b00;
      e_busy    = 1'b0;
      e_leds    = 4'b0000;
      e_cnt0    = 0;
      e_cnt1    = 0;
    end else begin
      e_ack0 = 1'b0;
      e_ack1 = 1'b0;
      if (pend_edge == edge_k) begin
        e_res  = pend_res;
        e_leds = 4'b0001 << pend_res;
        if (pend_id) begin
          e_ack1 = 1'b1;
          if (e_cnt1 < 255) e_cnt1++;
        end else begin
          e_ack0 = 1'b1;
          if (e_cnt0 < 255) e_cnt0++;
        end
      end
      if (edge_k >= free_edge && (req0 || req1)) begin
        if (req0 && req1) pend_id = !m_last;
        else              pend_id = req1;
        m_last    = pend_id;
        pend_res  = pend_id ? ref_compare(int'(a1), int'(b1))
                            : ref_compare(int'(a0), int'(b0));
        pend_edge = edge_k + 2;
        free_edge = edge_k + 3;
      end
      e_busy = (free_edge > edge_k);
      edge_k++;
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model on each falling edge.
  task automatic check_output();
    check("ack0", 32'(ack0), 32'(e_ack0));
    check("ack1", 32'(ack1), 32'(e_ack1));
    check("res_valid", 32'(res_valid), 32'(e_ack0 | e_ack1));
    check("busy", 32'(busy), 32'(e_busy));
    check("leds", 32'(leds), 32'(e_leds));
    if (rst || e_ack0 || e_ack1) check("res", 32'(res), 32'(e_res));
`ifdef CONTADORES_EN
    check("cnt0", 32'(cnt0), 32'(e_cnt0));
    check("cnt1", 32'(cnt1), 32'(e_cnt1));
`endif
  endtask

  always @(negedge clk) check_output();

  // One clock step: inputs move 1 time unit after the rising edge. A
  // requester withdraws its request as soon as it sees its ack, unless the
  // scenario wants requests held continuously.
  task automatic step();
    @(posedge clk);
    #1;
    if (!hold) begin
      if (ack0) req0 = 1'b0;
      if (ack1) req1 = 1'b0;
    end
  endtask

  task automatic wait_ack(output int steps, output bit got0, output bit got1);
    got0  = 1'b0;
    got1  = 1'b0;
    steps = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      steps++;
      if (ack0 || ack1) begin
        got0 = ack0;
        got1 = ack1;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("[TB] FAIL ack_timeout: got no ack, expected one within 20 cycles");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic apply_stimulus(input bit id, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b);
    if (id) begin a1 = a; b1 = b; req1 = 1'b1; end
    else    begin a0 = a; b0 = b; req0 = 1'b1; end
  endtask

  initial begin
    int  steps;
    bit  g0;
    bit  g1;
    int  ids[$];
    int  times[$];
    int  t;
    int  n0;

    n_checks = 0;
    n_fail   = 0;
    hold     = 1'b0;
    rst      = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;

    // Reset values
    #1;
    check("rst_leds", 32'(leds), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_res", 32'(res), 32'h0);
    do_reset();

    // Requester 0 alone: 9 vs 3
    $display("[TB] single request from requester 0");
    apply_stimulus(1'b0, 4'd9, 4'd3);
    wait_ack(steps, g0, g1);
    check("t1_latency", 32'(steps), 32'd3);
    check("t1_ack0", 32'(g0), 32'd1);
    check("t1_ack1", 32'(g1), 32'd0);
    check("t1_res", 32'(res), 32'b01);
    check("t1_leds", 32'(leds), 32'b0010);

    // Requester 1: 2 vs 7, then equal operands
    $display("[TB] requester 1, less-than then equal");
    apply_stimulus(1'b1, 4'd2, 4'd7);
    wait_ack(steps, g0, g1);
    check("t2_ack1", 32'(g1), 32'd1);
    check("t2_res", 32'(res), 32'b10);
    check("t2_leds", 32'(leds), 32'b0100);
    apply_stimulus(1'b1, 4'd5, 4'd5);
    wait_ack(steps, g0, g1);
    check("t2b_ack1", 32'(g1), 32'd1);
    check("t2b_res", 32'(res), 32'b00);
    check("t2b_leds", 32'(leds), 32'b0001);

    // Both held from reset: 0,1,0,1 every 3 cycles
    $display("[TB] continuous contention from reset");
    hold = 1'b1;
    rst  = 1'b1;
    apply_stimulus(1'b0, 4'd1, 4'd2);
    apply_stimulus(1'b1, 4'd3, 4'd3);
    step();
    rst = 1'b0;
    t = 0;
    for (int i = 0; i < 30 && ids.size() < 4; i++) begin
      step();
      t++;
      if (ack0 || ack1) begin
        ids.push_back(ack1 ? 1 : 0);
        times.push_back(t);
      end
    end
    check("t3_count", 32'(ids.size()), 32'd4);
    if (ids.size() == 4) begin
      for (int i = 0; i < 4; i++) check("t3_order", 32'(ids[i]), 32'(i % 2));
      check("t3_first", 32'(times[0]), 32'd3);
      for (int i = 1; i < 4; i++) check("t3_gap", 32'(times[i] - times[i-1]), 32'd3);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    hold = 1'b0;
    repeat (4) step();

    // Reset while the comparison is in flight
    $display("[TB] reset during compare");
    apply_stimulus(1'b0, 4'd7, 4'd1);
    step();
    #2;
    rst = 1'b1;
    #1;
    check("t4_ack0", 32'(ack0), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_leds", 32'(leds), 32'h0);
    step();
    step();
    rst = 1'b0;
    wait_ack(steps, g0, g1);
    check("t4_reserve", 32'(g0), 32'd1);
    check("t4_res", 32'(res), 32'b01);

    // Operands changed after the grant are ignored
    $display("[TB] operand change after grant");
    step();
    apply_stimulus(1'b0, 4'd9, 4'd3);
    step();
    a0 = 4'd0;
    wait_ack(steps, g0, g1);
    check("t5_ack0", 32'(g0), 32'd1);
    check("t5_res", 32'(res), 32'b01);
    repeat (2) step();

    // Randomized traffic against the model
    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      step();
      for (int r = 0; r < 2; r++) begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        ra = WIDTH'($urandom_range(0, 15));
        rb = ($urandom_range(0, 3) == 0) ? ra : WIDTH'($urandom_range(0, 15));
        if ($urandom_range(0, 2) == 0) begin
          if (r == 0 && !req0) apply_stimulus(1'b0, ra, rb);
          if (r == 1 && !req1) apply_stimulus(1'b1, ra, rb);
        end
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (6) step();

`ifdef CONTADORES_EN
    // Counter saturation: 300 services of requester 0
    $display("[TB] counter saturation");
    do_reset();
    hold = 1'b1;
    apply_stimulus(1'b0, 4'd4, 4'd4);
    n0 = 0;
    for (int i = 0; i < 1200 && n0 < 300; i++) begin
      step();
      if (ack0) n0++;
    end
    check("t6_services", 32'(n0), 32'd300);
    check("t6_cnt0", 32'(cnt0), 32'd255);
    check("t6_cnt1", 32'(cnt1), 32'd0);
    req0 = 1'b0;
    hold = 1'b0;
    repeat (4) step();
`else
    n0 = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arbitro_comparador.md
# arbitro_comparador

Round-robin arbiter and sequencer that shares one magnitude-compare-and-decode datapath between two requesters. Each requester presents an operand pair (A, B) with a request. The block grants one requester at a time, registers the operands, computes the A>B / B>A result, and returns it with a one-cycle acknowledge. The last result is also decoded one-hot onto a 4-bit LED bus. It sits between the two operand sources (switch/test logic) and the LED outputs.

## Interface
- WIDTH, 4, operand width in bits (≥1)
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- req0  input  1  request from requester 0; held high with operands stable until ack0
- a0, b0  input  WIDTH  operands of requester 0
- req1  input  1  request from requester 1; same rules as req0
- a1, b1  input  WIDTH  operands of requester 1
- ack0, ack1  output  1  one-cycle completion pulse to the served requester
- res  output  2  compare result: bit0=A>B, bit1=B>A, 00=equal; valid while an ack is high
- res_valid  output  1  high exactly when ack0 or ack1 is high
- busy  output  1  high in any state other than IDLE
- leds  output  4  one-hot decode of last delivered res, held until next result
- cnt0, cnt1  output  8  services completed per requester (only with CONTADORES_EN)

## Operation
- FSM states: IDLE, CMP, RESP. All outputs registered.
- IDLE: if any req is high, pick the winner, latch its operands and id, and go to CMP. Otherwise stay.
- Arbitration: round-robin. Pointer `last` holds the last served id.
  - Both requesting: serve the one ≠ `last`.
  - One requesting: serve it regardless of `last`.
  - `last` updates when the grant is taken.
- CMP: compare the latched operands unsigned, full WIDTH. Register res (exactly one of 00/01/10; 11 is never produced). Go to RESP.
- RESP: assert ack of the served id and res_valid for this one state. Update leds. Return to IDLE.
- leds decode: res 00→0001, 01→0010, 10→0100. 1000 is never driven.
- Requester protocol:
  - req is sampled only in IDLE. Operand changes after the grant edge are ignored.
  - Requester drops req in the cycle after ack.
  - If req is still high when the FSM re-enters IDLE, it is treated as a new request, subject to round-robin.
- A req that drops while the FSM is in CMP/RESP still completes; the ack is issued anyway.
- Reset values: state IDLE, `last`=1 (so requester 0 wins the first contention), ack0=ack1=0, res=00, res_valid=0, busy=0, leds=0000, cnt0=cnt1=0.
- Reset mid-operation: the in-flight comparison is aborted, no ack is issued, and all outputs return to reset values asynchronously.

## Timing
- Request sampled at edge N (state IDLE) → CMP after N → res registered at N+1 → ack/res_valid high during the cycle after edge N+2 only.
- Latency from sampled request to ack: 3 edges. Max throughput: one service per 3 cycles.
- busy rises after edge N and falls after edge N+3 (back in IDLE).
- leds change at edge N+2, concurrent with ack.
- Back-to-back, both requesters continuously high: grants alternate 0,1,0,1…; acks spaced 3 cycles apart.

## Configuration
- Macro CONTADORES_EN.
- Defined: cnt0/cnt1 ports exist. The matching counter increments by 1 on the same edge that raises ack0/ack1 and saturates at 255 (no wrap). Reset clears both.
- Undefined: cnt0/cnt1 ports and counter registers are absent. All other behaviour is identical.

## Test plan
- Reset, then req0=1, a0=9, b0=3 → ack0 one cycle, 3 edges after sampling; res=01; leds=0010; ack1 never high.
- req1=1, a1=2, b1=7; then a1=b1=5 → res=10 / leds=0100, then res=00 / leds=0001.
- req0 and req1 held high from reset → first ack is ack0, then alternating ack1, ack0, ack1, with 3-cycle spacing.
- Assert rst during CMP with req0 high → no ack0; leds=0000, busy=0; after release, req0 is served afresh.
- Change a0 during CMP (after grant) → res reflects the originally latched operands.
- With CONTADORES_EN: 300 consecutive req0 services → cnt0 stops at 255, cnt1=0.
